// File: rtl/ahb_pkg.sv
// Shared AHB-Lite codes and responder state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HSIZE_BYTE  = 3'd0;
    localparam logic [2:0] HSIZE_HALF  = 3'd1;
    localparam logic [2:0] HSIZE_WORD  = 3'd2;
    localparam logic [2:0] HSIZE_DWORD = 3'd3;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } slv_state_t;

endpackage

// File: rtl/ahb_slv_mem.sv
// DEPTH x DW word array, one byte-enabled synchronous write port, one asynchronous read port.
// Latency: writes land on the clock edge; reads are combinational.
// Backpressure: none, always accepts.
module ahb_slv_mem #(
    parameter int DW    = 32,
    parameter int DEPTH = 256,
    parameter int IW    = $clog2(DEPTH)
) (
    input  logic            hclk,
    input  logic            we,
    input  logic [IW-1:0]   widx,
    input  logic [DW/8-1:0] wbe,
    input  logic [DW-1:0]   wdat,
    input  logic [IW-1:0]   ridx,
    output logic [DW-1:0]   rdat
);

    logic [DW-1:0] mem [DEPTH];

    // Contents are intentionally not reset.
    always_ff @(posedge hclk) begin
        if (we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (wbe[b]) mem[widx][b*8 +: 8] <= wdat[b*8 +: 8];
            end
        end
    end

    assign rdat = mem[ridx];

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: byte/half/word writes and reads; AHB_SLV_ERR_RESP_EN adds hresp and ERROR replies.
// Latency: WAIT_CYCLES hready-low cycles per data phase; zero-wait reads (with write forwarding) when WAIT_CYCLES=0.
// Backpressure: hready low stalls the master's data phase; the next address phase is held, not sampled.
module ahb_sram_slave
    import ahb_pkg::*;
#(
    parameter int DW          = 32,
    parameter int AW          = 32,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 0
) (
    input  logic          hclk,
    input  logic          hreset_n,
    input  logic          hsel,
    input  logic [AW-1:0] haddr,
    input  logic [1:0]    htrans,
    input  logic [2:0]    hsize,
    input  logic          hwrite,
    input  logic [DW-1:0] hwdata,
    output logic [DW-1:0] hrdata,
    output logic          hready
`ifdef AHB_SLV_ERR_RESP_EN
    ,
    output logic          hresp
`endif
);

    localparam int BW  = DW / 8;
    localparam int OFS = $clog2(BW);
    localparam int IW  = $clog2(DEPTH);
`ifdef AHB_SLV_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam logic [3:0] WC_LAST = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    slv_state_t    state;
    logic [3:0]    wait_cnt;
    logic          p_write;
    logic [IW-1:0] p_idx;
    logic [BW-1:0] p_be;

    logic          accept;
    logic          oor;
    logic          req_err;
    logic          mem_we;
    logic [IW-1:0] req_idx;
    logic [IW-1:0] rd_idx;
    logic [BW-1:0] req_be;
    logic [2:0]    eff_size;
    logic [DW-1:0] mem_rdat;
    logic [DW-1:0] fwd_dat;

    assign accept  = hsel && hready && (htrans == HTRANS_NONSEQ || htrans == HTRANS_SEQ);
    assign req_idx = haddr[IW+OFS-1:OFS];
    assign oor     = |haddr[AW-1:IW+OFS];
    assign req_err = ERR_EN && (oor || (hsize > 3'(OFS)));
    assign mem_we  = (state == ST_DATA) && p_write;
    // A read leaving WAIT uses its captured index; a zero-wait read uses the live address.
    assign rd_idx  = (state == ST_WAIT) ? p_idx : req_idx;

    // A lane is enabled when it falls in the same size-aligned block as the address.
    always_comb begin
        eff_size = (hsize > 3'(OFS)) ? 3'(OFS) : hsize;
        for (int b = 0; b < BW; b++) begin
            req_be[b] = ((b >> eff_size) == (int'(haddr[OFS-1:0]) >> eff_size));
        end
    end

    // Write committing on the same edge a zero-wait read loads: merge its lanes in.
    always_comb begin
        fwd_dat = mem_rdat;
        for (int b = 0; b < BW; b++) begin
            if (mem_we && p_be[b] && (p_idx == req_idx)) fwd_dat[b*8 +: 8] = hwdata[b*8 +: 8];
        end
    end

    ahb_slv_mem #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_mem (
        .hclk (hclk),
        .we   (mem_we),
        .widx (p_idx),
        .wbe  (p_be),
        .wdat (hwdata),
        .ridx (rd_idx),
        .rdat (mem_rdat)
    );

    always_ff @(posedge hclk or negedge hreset_n) begin
        if (!hreset_n) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            hready   <= 1'b1;
            hrdata   <= '0;
            p_write  <= 1'b0;
            p_idx    <= '0;
            p_be     <= '0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (wait_cnt == WC_LAST) begin
                        state    <= ST_DATA;
                        hready   <= 1'b1;
                        wait_cnt <= 4'd0;
                        if (!p_write) hrdata <= mem_rdat;
                    end else begin
                        wait_cnt <= wait_cnt + 4'd1;
                    end
                end
                ST_ERR1: begin
                    state  <= ST_ERR2;
                    hready <= 1'b1;
                end
                default: begin
                    if (accept) begin
                        p_write <= hwrite && !req_err;
                        p_idx   <= req_idx;
                        p_be    <= req_be;
                        if (req_err) begin
                            state  <= ST_ERR1;
                            hready <= 1'b0;
                        end else if (WAIT_CYCLES > 0) begin
                            state  <= ST_WAIT;
                            hready <= 1'b0;
                        end else begin
                            state <= ST_DATA;
                            if (!hwrite) hrdata <= fwd_dat;
                        end
                    end else begin
                        state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

`ifdef AHB_SLV_ERR_RESP_EN
    assign hresp = (state == ST_ERR1 || state == ST_ERR2) ? HRESP_ERROR : HRESP_OKAY;
`endif

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
Synthesizable AHB-Lite responder that answers the AHB master bus-functional model.
- Backs a word-organized on-chip memory; supports byte, halfword and word writes, and reads.
- Inserts a parameterized number of wait states per data phase.
- Sits as the single slave on the bench/system AHB segment; the same register-file template is reused for peripheral register banks.

Parameters:
- DW, 32, data width (32 or 64).
- AW, 32, address width.
- DEPTH, 256, number of DW-bit words; word index = haddr[log2(DEPTH)+log2(DW/8)-1 : log2(DW/8)].
- WAIT_CYCLES, 0, hready-low cycles per data phase (0..15).

Ports:
- hclk, input, 1, bus clock.
- hreset_n, input, 1, asynchronous active-low reset.
- hsel, input, 1, slave select (tie high in single-slave bench).
- haddr, input, AW, transfer address.
- htrans, input, 2, IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hsize, input, 3, 0=byte, 1=halfword, 2=word, 3=dword.
- hwrite, input, 1, 1=write.
- hwdata, input, DW, write data, valid in the data phase.
- hrdata, output, DW, read data.
- hready, output, 1, data phase complete.
- hresp, output, 1, ERROR response; present only with AHB_SLV_ERR_RESP_EN.

Behaviour:
- Clock and reset are decided: one clock, hclk; reset is asynchronous and active-low, named hreset_n.
- Reset values:
  - hready=1, hrdata=0, hresp=0.
  - State IDLE, wait counter=0.
  - Memory contents are not reset.
- Address-phase sampling:
  - Fields are sampled on a posedge hclk where hready=1, hsel=1 and htrans[1]=1.
  - NONSEQ and SEQ are treated identically.
  - BUSY and IDLE give a zero-wait OKAY and have no effect.
- States:
  - IDLE: no data phase pending. A valid transfer moves to WAIT if WAIT_CYCLES>0, otherwise to DATA.
  - WAIT: hready=0. The counter counts WAIT_CYCLES cycles, then the block moves to DATA.
  - DATA: hready=1, final data-phase cycle. A new valid transfer sampled here re-enters WAIT or DATA. Otherwise the block returns to IDLE.
- Read path:
  - hrdata is registered and loaded on the edge entering DATA.
  - For WAIT_CYCLES=0 that is the address-sampling edge, giving zero-wait reads.
  - hrdata holds its value until the next read enters DATA. Writes, idle cycles and errors do not change it.
- Write path:
  - hwdata lanes are committed on the edge that ends DATA.
  - Byte enables derive from hsize and the haddr low bits. Misaligned low bits are ignored; halfword and word accesses align down.
  - hsize above log2(DW/8) is treated as a full-width write.
- Back-to-back write A, then read A with WAIT_CYCLES=0: the read's load edge equals the write's commit edge. hrdata is forwarded from the merged write data, so the read returns the new value.
- Out-of-range word index (address beyond DEPTH words) without the optional feature: the upper address bits are ignored and the index wraps modulo DEPTH.
- hsel=0 with htrans active: treated as IDLE.
- The address phase of the next transfer is held by the master while hready=0 and is not sampled.
- Reset mid-transfer: the block returns to reset values immediately, and any uncommitted write is dropped.

Optional Feature:
Macro AHB_SLV_ERR_RESP_EN.
- With the macro defined:
  - The hresp port exists.
  - Out-of-range addresses and hsize>log2(DW/8) give a two-cycle ERROR, skipping wait states: cycle 1 hready=0 hresp=1; cycle 2 hready=1 hresp=1.
  - The write is suppressed and hrdata is unchanged.
- Without the macro: there is no hresp port, and out-of-range addresses wrap as described above.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS codes: IDLE, BUSY, NONSEQ, SEQ.
  - HSIZE codes.
  - HRESP OKAY and ERROR.
  - Slave state encoding.
- One natural sub-module, ahb_slv_mem: DEPTH x DW array with one byte-enabled write port and one read port.
- The bus FSM, counter, byte-enable decode and forwarding stay in the top module.

Test Plan:
- Reset with hready sampled → hready=1, hrdata=0; write 0xDEADBEEF to 0x10, then read 0x10 → hrdata=0xDEADBEEF, zero wait.
- Byte write 0xAA to 0x13 over word 0x11223344 at 0x10 → read 0x10 returns 0xAA223344; halfword write 0x5566 at 0x12 → read returns 0x55663344.
- WAIT_CYCLES=3, read 0x20 → exactly 3 cycles with hready=0, then data is valid when hready returns to 1; hwdata is held throughout a write.
- Back-to-back write 0x12345678 to 0x40, then read 0x40 with WAIT_CYCLES=0 → read returns 0x12345678 via forwarding.
- With AHB_SLV_ERR_RESP_EN, write to 0x400 (DEPTH=256) → hresp=1 for 2 cycles with hready 0 then 1, and memory at wrapped index 0 is unchanged. Without the macro, the same write lands in word 0.
- Assert hreset_n low during WAIT of a write → hready=1 asynchronously, and the targeted word keeps its old value.
